// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cpu_ctrl_pkg                                                     |
// | Brief   : States, opcodes, ALU codes and IR field positions for the        |
// |           hardwired control sequencer.                                     |
// | Revision: 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    localparam int c_ST_W = 4;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 4'd0;
    localparam logic [c_ST_W-1:0] c_ST_T0   = 4'd1;
    localparam logic [c_ST_W-1:0] c_ST_T1   = 4'd2;
    localparam logic [c_ST_W-1:0] c_ST_T1W  = 4'd3;
    localparam logic [c_ST_W-1:0] c_ST_T2   = 4'd4;
    localparam logic [c_ST_W-1:0] c_ST_T3   = 4'd5;
    localparam logic [c_ST_W-1:0] c_ST_T4   = 4'd6;
    localparam logic [c_ST_W-1:0] c_ST_T5   = 4'd7;
    localparam logic [c_ST_W-1:0] c_ST_T6   = 4'd8;
    localparam logic [c_ST_W-1:0] c_ST_HALT = 4'd9;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;
    localparam logic [3:0] ALU_DIV = 4'd6;

    localparam int c_IR_OP_LSB    = 27;
    localparam int c_IR_RA_LSB    = 23;
    localparam int c_IR_RB_LSB    = 19;
    localparam int c_IR_RC_LSB    = 15;
    localparam int c_REG_FIELD_W  = 4;

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_alu4(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_field_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reg_field_decoder                                                |
// | Brief   : Register field to one-hot select with enable.                    |
// | Revision: 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
module reg_field_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int FIELD_W  = c_REG_FIELD_W
) (
    input  logic                en,
    input  logic [FIELD_W-1:0]  field,
    output logic [NUM_REGS-1:0] onehot
);

    // Bits the field can never address stay low when NUM_REGS exceeds the field range
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        if (i < (1 << FIELD_W)) begin : g_hit
            assign onehot[i] = en && (field == FIELD_W'(i));
        end else begin : g_none
            assign onehot[i] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : control_sequencer                                                |
// | Brief   : Hardwired T-state control unit for fetch and 3-register ALU ops. |
// | Revision: 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
module control_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run_req,
    input  logic                stop_req,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    input  logic                alu_done,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                z_in,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic [3:0]          alu_op,
    output logic [NUM_REGS-1:0] gpr_in,
    output logic [NUM_REGS-1:0] gpr_out,
    output logic                running,
    output logic                illegal_op,
    output logic                bus_err
);
    import cpu_ctrl_pkg::*;

    localparam int                 c_CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(MEM_TIMEOUT);

    logic [c_ST_W-1:0]        r_state, w_state_next, w_end_state;
    logic [c_CNT_W-1:0]       r_wait_cnt, w_cnt_next;
    logic                     r_stop;
    logic [4:0]               w_op;
    logic [c_REG_FIELD_W-1:0] w_ra, w_rb, w_rc, w_out_field;
    logic                     w_gpr_in_en, w_gpr_out_en;
    logic                     w_unused_ir;

    assign w_op        = ir[c_IR_OP_LSB +: 5];
    assign w_ra        = ir[c_IR_RA_LSB +: c_REG_FIELD_W];
    assign w_rb        = ir[c_IR_RB_LSB +: c_REG_FIELD_W];
    assign w_rc        = ir[c_IR_RC_LSB +: c_REG_FIELD_W];
    assign w_unused_ir = ^ir[c_IR_RC_LSB-1:0];
    assign w_end_state = r_stop ? c_ST_IDLE : c_ST_T0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= '0;
            r_stop     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_cnt_next;
            r_stop     <= (w_state_next == c_ST_IDLE) ? 1'b0 : (r_stop | stop_req);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_gpr_in_en  = 1'b0;
        w_gpr_out_en = 1'b0;
        w_out_field  = w_rb;
        pc_out       = 1'b0;
        mar_in       = 1'b0;
        inc_pc       = 1'b0;
        z_in         = 1'b0;
        zlow_out     = 1'b0;
        zhigh_out    = 1'b0;
        pc_in        = 1'b0;
        read         = 1'b0;
        mdr_in       = 1'b0;
        mdr_out      = 1'b0;
        ir_in        = 1'b0;
        y_in         = 1'b0;
        hi_in        = 1'b0;
        lo_in        = 1'b0;
        alu_op       = ALU_NOP;
        illegal_op   = 1'b0;
        running      = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT);
        bus_err      = (r_state == c_ST_HALT);

        case (r_state)
            c_ST_IDLE: begin
                if (run_req && !stop_req) w_state_next = c_ST_T0;
            end
            c_ST_T0: begin
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                inc_pc       = 1'b1;
                z_in         = 1'b1;
                w_state_next = c_ST_T1;
            end
            c_ST_T1: begin
                zlow_out     = 1'b1;
                pc_in        = 1'b1;
                read         = 1'b1;
                mdr_in       = 1'b1;
                w_state_next = mem_ready ? c_ST_T2 : c_ST_T1W;
            end
            c_ST_T1W: begin
                read       = 1'b1;
                mdr_in     = 1'b1;
                w_cnt_next = r_wait_cnt + 1'b1;
                // A late mem_ready on the final allowed cycle still wins over the timeout
                if (mem_ready)                     w_state_next = c_ST_T2;
                else if (w_cnt_next == c_TIMEOUT)  w_state_next = c_ST_HALT;
            end
            c_ST_T2: begin
                mdr_out      = 1'b1;
                ir_in        = 1'b1;
                w_state_next = c_ST_T3;
            end
            c_ST_T3: begin
                w_gpr_out_en = 1'b1;
                y_in         = 1'b1;
                if (is_alu4(w_op) || is_muldiv(w_op)) begin
                    w_state_next = c_ST_T4;
                end else begin
                    illegal_op   = 1'b1;
                    w_state_next = w_end_state;
                end
            end
            c_ST_T4: begin
                w_gpr_out_en = 1'b1;
                w_out_field  = w_rc;
                alu_op       = alu_code(w_op);
                z_in         = 1'b1;
                if (!is_muldiv(w_op) || alu_done) w_state_next = c_ST_T5;
            end
            c_ST_T5: begin
                zlow_out = 1'b1;
                if (is_muldiv(w_op)) begin
                    lo_in        = 1'b1;
                    w_state_next = c_ST_T6;
                end else begin
                    w_gpr_in_en  = 1'b1;
                    w_state_next = w_end_state;
                end
            end
            c_ST_T6: begin
                zhigh_out    = 1'b1;
                hi_in        = 1'b1;
                w_state_next = w_end_state;
            end
            c_ST_HALT: w_state_next = c_ST_HALT;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    reg_field_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(c_REG_FIELD_W)) u_dec_gpr_in (
        .en     (w_gpr_in_en),
        .field  (w_ra),
        .onehot (gpr_in)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(c_REG_FIELD_W)) u_dec_gpr_out (
        .en     (w_gpr_out_en),
        .field  (w_out_field),
        .onehot (gpr_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_control_sequencer                                             |
// | Brief   : Scoreboard bench for the control sequencer T-state outputs.     |
// | Revision: 1.0 - initial release                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T1W = 3, S_T2 = 4, S_T3 = 5;
    localparam int S_T4 = 6, S_T5 = 7, S_T6 = 8, S_HALT = 9;

    localparam logic [13:0] c_PC_OUT = 14'h2000, c_MAR_IN = 14'h1000, c_INC_PC = 14'h0800;
    localparam logic [13:0] c_Z_IN = 14'h0400, c_ZLOW_OUT = 14'h0200, c_ZHIGH_OUT = 14'h0100;
    localparam logic [13:0] c_PC_IN = 14'h0080, c_READ = 14'h0040, c_MDR_IN = 14'h0020;
    localparam logic [13:0] c_MDR_OUT = 14'h0010, c_IR_IN = 14'h0008, c_Y_IN = 14'h0004;
    localparam logic [13:0] c_HI_IN = 14'h0002, c_LO_IN = 14'h0001;

    typedef struct packed {
        logic [13:0] strb;
        logic [3:0]  alu;
        logic [15:0] gin;
        logic [15:0] gout;
        logic        run;
        logic        ill;
        logic        berr;
    } ovec_t;

    typedef struct {
        int          st;
        logic [31:0] ir;
        logic        run;
        logic        stop;
        logic        mem;
        logic        done;
    } step_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        run_req = 1'b0, stop_req = 1'b0, mem_ready = 1'b0, alu_done = 1'b0;
    logic [31:0] ir = '0;
    logic        pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read;
    logic        mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in, running, illegal_op, bus_err;
    logic [3:0]  alu_op;
    logic [15:0] gpr_in, gpr_out;
    ovec_t       obs;

    ovec_t exp_q[$];
    step_t stim_q[$];
    int    n_vec = 0, n_bad = 0;

    control_sequencer #(.NUM_REGS(16), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .run_req(run_req), .stop_req(stop_req), .ir(ir),
        .mem_ready(mem_ready), .alu_done(alu_done), .pc_out(pc_out), .mar_in(mar_in),
        .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
        .pc_in(pc_in), .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op), .gpr_in(gpr_in),
        .gpr_out(gpr_out), .running(running), .illegal_op(illegal_op), .bus_err(bus_err)
    );

    assign obs = {pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in,
                  mdr_out, ir_in, y_in, hi_in, lo_in, alu_op, gpr_in, gpr_out,
                  running, illegal_op, bus_err};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected Datapath strobes for a given T-state, written from the instruction table
    function automatic ovec_t model(input int st, input logic [31:0] irv);
        ovec_t      v;
        logic [4:0] op;
        logic       md, legal;
        v     = '0;
        op    = irv[31:27];
        md    = (op == OP_MUL) || (op == OP_DIV);
        legal = md || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        v.run = (st != S_IDLE) && (st != S_HALT);
        case (st)
            S_T0:  v.strb = c_PC_OUT | c_MAR_IN | c_INC_PC | c_Z_IN;
            S_T1:  v.strb = c_ZLOW_OUT | c_PC_IN | c_READ | c_MDR_IN;
            S_T1W: v.strb = c_READ | c_MDR_IN;
            S_T2:  v.strb = c_MDR_OUT | c_IR_IN;
            S_T3: begin
                v.strb = c_Y_IN;
                v.gout = 16'h1 << irv[22:19];
                v.ill  = !legal;
            end
            S_T4: begin
                v.strb = c_Z_IN;
                v.gout = 16'h1 << irv[18:15];
                case (op)
                    OP_ADD:  v.alu = ALU_ADD;
                    OP_SUB:  v.alu = ALU_SUB;
                    OP_AND:  v.alu = ALU_AND;
                    OP_OR:   v.alu = ALU_OR;
                    OP_MUL:  v.alu = ALU_MUL;
                    OP_DIV:  v.alu = ALU_DIV;
                    default: v.alu = ALU_NOP;
                endcase
            end
            S_T5: begin
                if (md) v.strb = c_ZLOW_OUT | c_LO_IN;
                else begin
                    v.strb = c_ZLOW_OUT;
                    v.gin  = 16'h1 << irv[26:23];
                end
            end
            S_T6:   v.strb = c_ZHIGH_OUT | c_HI_IN;
            S_HALT: v.berr = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic plan(input int st, input logic [31:0] irv, input logic run,
                        input logic stop, input logic mem, input logic done);
        step_t s;
        s.st = st; s.ir = irv; s.run = run; s.stop = stop; s.mem = mem; s.done = done;
        exp_q.push_back(model(st, irv));
        stim_q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; run_req = 1'b0; stop_req = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        step_t s; ovec_t e;
        reset_n = 1'b0; run_req = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if (obs !== model(S_IDLE, ir)) begin
            n_bad++; $display("FAIL reset_idle: got %h want %h", obs, model(S_IDLE, ir));
        end
        run_req = 1'b0; reset_n = 1'b1;
        plan(S_IDLE, 32'h0, 1, 1, 0, 0);
        plan(S_IDLE, 32'h0, 0, 0, 0, 0);
        plan(S_IDLE, 32'h0, 1, 0, 1, 0);
        plan(S_T0,   32'h0, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL reset st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_div();
        step_t s; ovec_t e;
        logic [31:0] iv = 32'h4A920000;
        do_reset();
        plan(S_IDLE, iv, 1, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0);  plan(S_T1, iv, 0, 0, 1, 0);
        plan(S_T2, iv, 0, 0, 1, 0);  plan(S_T3, iv, 0, 0, 1, 0);
        plan(S_T4, iv, 0, 0, 1, 0);  plan(S_T4, iv, 0, 0, 1, 0);
        plan(S_T4, iv, 0, 0, 1, 0);  plan(S_T4, iv, 0, 0, 1, 1);
        plan(S_T5, iv, 0, 0, 1, 0);  plan(S_T6, iv, 0, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL div st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_add();
        step_t s; ovec_t e;
        logic [31:0] iv = 32'h18918000;
        do_reset();
        plan(S_IDLE, iv, 1, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0); plan(S_T2, iv, 0, 0, 1, 0);
        plan(S_T3, iv, 0, 0, 1, 0); plan(S_T4, iv, 0, 0, 1, 0); plan(S_T5, iv, 0, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL add st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_back_to_back();
        step_t s; ovec_t e;
        logic [4:0]  ops [3] = '{OP_SUB, OP_AND, OP_OR};
        logic [31:0] iv;
        do_reset();
        plan(S_IDLE, 32'h0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            iv = {ops[k], 4'($urandom_range(15)), 4'($urandom_range(15)),
                  4'($urandom_range(15)), 15'h0};
            plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0);
            plan(S_T2, iv, 0, 0, 1, 0); plan(S_T3, iv, 0, 0, 1, 0);
            plan(S_T4, iv, 0, (k == 2), 1, 0); plan(S_T5, iv, 0, 0, 1, 0);
        end
        plan(S_IDLE, 32'h0, 0, 0, 1, 0);
        plan(S_IDLE, 32'h0, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL b2b st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_mem_wait();
        step_t s; ovec_t e;
        logic [31:0] iv = 32'h18918000;
        do_reset();
        plan(S_IDLE, iv, 1, 0, 0, 0);
        plan(S_T0, iv, 0, 0, 0, 0);
        plan(S_T1, iv, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) plan(S_T1W, iv, 0, 0, 0, 0);
        plan(S_T1W, iv, 0, 0, 1, 0);
        plan(S_T2, iv, 0, 0, 1, 0); plan(S_T3, iv, 0, 0, 1, 0);
        plan(S_T4, iv, 0, 0, 1, 0); plan(S_T5, iv, 0, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL memwait st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_timeout();
        step_t s; ovec_t e;
        do_reset();
        plan(S_IDLE, 32'h0, 1, 0, 0, 0);
        plan(S_T0, 32'h0, 0, 0, 0, 0);
        plan(S_T1, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) plan(S_T1W, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)  plan(S_HALT, 32'h0, 1, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL timeout st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
        do_reset();
        plan(S_IDLE, 32'h0, 1, 0, 1, 0);
        plan(S_T0, 32'h0, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL halt_exit st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_illegal();
        step_t s; ovec_t e;
        logic [31:0] iv = {5'b11111, 4'd7, 4'd9, 4'd12, 15'h0};
        do_reset();
        plan(S_IDLE, iv, 1, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0); plan(S_T2, iv, 0, 0, 1, 0);
        plan(S_T3, iv, 0, 0, 1, 0); plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL illegal st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
    endtask

    task automatic test_stop_reset();
        step_t s; ovec_t e;
        logic [31:0] iv = {OP_MUL, 4'd14, 4'd0, 4'd15, 15'h0};
        do_reset();
        plan(S_IDLE, iv, 1, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0); plan(S_T2, iv, 0, 0, 1, 0);
        plan(S_T3, iv, 0, 1, 1, 0); plan(S_T4, iv, 0, 0, 1, 0); plan(S_T4, iv, 0, 0, 1, 1);
        plan(S_T5, iv, 0, 0, 1, 0); plan(S_T6, iv, 0, 0, 1, 0);
        plan(S_IDLE, iv, 0, 0, 1, 0); plan(S_IDLE, iv, 1, 0, 1, 0);
        plan(S_T0, iv, 0, 0, 1, 0); plan(S_T1, iv, 0, 0, 1, 0); plan(S_T2, iv, 0, 0, 1, 0);
        plan(S_T3, iv, 0, 0, 1, 0); plan(S_T4, iv, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            s = stim_q.pop_front(); e = exp_q.pop_front();
            ir = s.ir; #1;
            n_vec++;
            if (obs !== e) begin n_bad++; $display("FAIL stop st=%0d: got %h want %h", s.st, obs, e); end
            run_req = s.run; stop_req = s.stop; mem_ready = s.mem; alu_done = s.done;
        end
        // Mid-T4 reset must clear outputs before the next clock edge
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== model(S_IDLE, iv)) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", obs, model(S_IDLE, iv));
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_div();
        test_add();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_illegal();
        test_stop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
